reg_writeback: RTL and testbench
================================

// Module: reg_writeback
// PURPOSE
//   Write-side initiator for the 64x8 register file: buffers results from ALU/load paths, issues one RF write per
//   granted cycle on the wr/ad/rd port, and forwards pending (not-yet-written) values onto the read-port results.
//   Sits between the execute stage and the register file; decouples producers from write-port contention.
// PARAMETERS
//   DW     8  data width (matches register width)
//   AW     6  register address width (64 registers)
//   DEPTH  4  pending-write FIFO depth, power of 2, >= 2
// PORTS
//   clk       in   1    single clock, all state on posedge
//   rst       in   1    synchronous reset, active-high
//   in_valid  in   1    producer has a result
//   in_ready  out  1    FIFO can accept; push = in_valid & in_ready
//   in_addr   in   AW   destination register
//   in_data   in   DW   result value
//   rf_wr     out  1    write request to register file (wr)
//   rf_ad     out  AW   write address (ad)
//   rf_rd     out  DW   write data (rd)
//   rf_gnt    in   1    write port granted this cycle; write commits at posedge when rf_wr & rf_gnt
//   aa, ab    in   AW   read addresses presented to register file
//   rf_ra     in   DW   register file read data A (raw)
//   rf_rb     in   DW   register file read data B (raw)
//   ra_out    out  DW   read data A after forwarding
//   rb_out    out  DW   read data B after forwarding
//   count     out  $clog2(DEPTH)+1  entries pending (FIFO + issue register)
// BEHAVIOUR
//   Reset: rf_wr=0, rf_ad=0, rf_rd=0, count=0, in_ready=1 from the cycle after rst sampled high; pending data dropped.
//   State machine (2 states): IDLE (issue register empty, rf_wr=0) / ISSUE (rf_wr=1, rf_ad/rf_rd stable).
//     IDLE->ISSUE: FIFO non-empty at posedge; head popped into registered rf_ad/rf_rd.
//     ISSUE & rf_gnt & FIFO non-empty -> stay ISSUE, load next head (back-to-back writes, 1/cycle).
//     ISSUE & rf_gnt & FIFO empty -> IDLE. ISSUE & !rf_gnt -> hold; rf_ad/rf_rd must not change.
//   Latency: push into empty unit at edge N -> rf_wr=1 after edge N+1 -> committed at edge N+2 with rf_gnt=1.
//   in_ready = (FIFO occupancy < DEPTH); combinational from registered count only, never from rf_gnt.
//   Push on a full-FIFO cycle is not accepted even if a pop happens same cycle (no pass-through).
//   Simultaneous push and pop: both take effect; occupancy unchanged. Pointers wrap modulo DEPTH.
//   Same-address entries written in push order; no coalescing.
//   count = FIFO occupancy + (state==ISSUE); max DEPTH+1.
// CONFIGURATION
//   WB_BYPASS_EN defined: ra_out = youngest pending value with addr==aa (FIFO entries youngest-first, then issue
//     register), else rf_ra; same for rb_out/ab. Combinational, zero-cycle. in-flight push this cycle not forwarded.
//   WB_BYPASS_EN undefined: ra_out=rf_ra, rb_out=rf_rb; no compare logic; caller must stall on count!=0 hazards.
// STRUCTURE
//   Shared package cpu_pkg: DW/AW constants, typedef wb_entry_t {addr[AW], data[DW]}, WB_IDLE/WB_ISSUE encodings.
//   One sub-module: wb_fifo (DEPTH x wb_entry_t, push/pop, full/empty, occupancy, flat entry view for bypass).
//   Top holds FSM, issue register, bypass muxes.
// TESTING
//   1 Reset: rst=1 two cycles with FIFO holding 3 entries -> count=0, rf_wr=0, in_ready=1; no writes after rst.
//   2 Single write: push (ad=1, data=8'd12), rf_gnt=1 -> rf_wr=1 exactly one cycle, ad=1, rd=12; count 1->0.
//   3 Backpressure: rf_gnt=0, push 5 entries -> in_ready=0 after 4th FIFO entry, count=5, rf_ad/rf_rd frozen;
//     release rf_gnt -> 5 writes on 5 consecutive cycles in push order.
//   4 Ordering/wrap: 10 pushes to addr 10 data 1..10 with random gnt -> RF model addr 10 ends at 10, all in order.
//   5 Bypass (WB_BYPASS_EN): pending writes addr 10 = 8'h33 then 8'h44, aa=10, rf_ra=8'h00 -> ra_out=8'h44;
//     ab=1 with no pending -> rb_out=rf_rb. Without macro -> ra_out=8'h00.
//   6 Simultaneous push/pop at occupancy 2 -> occupancy stays 2, no entry lost or duplicated.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, write-back entry type and write-back FSM encodings.
package cpu_pkg;
    localparam int DW = 8;
    localparam int AW = 6;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_ISSUE = 1'b1
    } wb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: pending-write FIFO with occupancy and an oldest-first flat view of live entries.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                din,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occ,
    output wb_entry_t [DEPTH-1:0]    view,
    output logic [DEPTH-1:0]         vld
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t mem [DEPTH];
    logic [PW-1:0] wp, rp;

    assign full  = occ == (PW+1)'(DEPTH);
    assign empty = occ == '0;
    assign head  = mem[rp];

    // view[0] is the oldest entry; vld marks slots currently holding data
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        assign view[i] = mem[rp + PW'(i)];
        assign vld[i]  = (PW+1)'(i) < occ;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            occ <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            occ <= occ + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: buffers results and issues one register-file write per granted cycle.
// Optional WB_BYPASS_EN forwards pending values onto the read-port results.
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_addr,
    input  logic [DW-1:0]          in_data,
    output logic                   rf_wr,
    output logic [AW-1:0]          rf_ad,
    output logic [DW-1:0]          rf_rd,
    input  logic                   rf_gnt,
    input  logic [AW-1:0]          aa,
    input  logic [AW-1:0]          ab,
    input  logic [DW-1:0]          rf_ra,
    input  logic [DW-1:0]          rf_rb,
    output logic [DW-1:0]          ra_out,
    output logic [DW-1:0]          rb_out,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    wb_state_t state;
    wb_entry_t iss, head, in_entry;
    wb_entry_t [DEPTH-1:0] view;
    logic [DEPTH-1:0] vld;
    logic push, pop, full, empty;
    logic [PW:0] occ;

    assign in_entry = '{addr: in_addr, data: in_data};
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && (state == WB_IDLE || rf_gnt);
    assign rf_wr    = state == WB_ISSUE;
    assign rf_ad    = iss.addr;
    assign rf_rd    = iss.data;
    assign count    = occ + (PW+1)'(state == WB_ISSUE);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_entry),
        .head  (head),
        .full  (full),
        .empty (empty),
        .occ   (occ),
        .view  (view),
        .vld   (vld)
    );

    // the issue register only advances when idle or when the current write is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_IDLE;
            iss   <= '0;
        end else if (state == WB_IDLE || rf_gnt) begin
            state <= empty ? WB_IDLE : WB_ISSUE;
            if (!empty) iss <= head;
        end
    end

`ifdef WB_BYPASS_EN
    // oldest to youngest so the youngest matching entry wins
    always_comb begin
        ra_out = rf_ra;
        rb_out = rf_rb;
        if (state == WB_ISSUE && iss.addr == aa) ra_out = iss.data;
        if (state == WB_ISSUE && iss.addr == ab) rb_out = iss.data;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && view[i].addr == aa) ra_out = view[i].data;
            if (vld[i] && view[i].addr == ab) rb_out = view[i].data;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{aa, ab, view, vld};
    assign ra_out = rf_ra;
    assign rb_out = rf_rb;
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: randomized scoreboard bench for reg_writeback against a queue-based model.
module tb_reg_writeback;
    logic clk = 0, rst = 1;
    logic in_valid = 0, rf_gnt = 0;
    logic in_ready, rf_wr;
    logic [5:0] in_addr = 0, aa = 0, ab = 0, rf_ad;
    logic [7:0] in_data = 0, rf_ra = 0, rf_rb = 0, rf_rd, ra_out, rb_out;
    logic [2:0] count;

    reg_writeback #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .rf_wr(rf_wr), .rf_ad(rf_ad),
        .rf_rd(rf_rd), .rf_gnt(rf_gnt), .aa(aa), .ab(ab), .rf_ra(rf_ra),
        .rf_rb(rf_rb), .ra_out(ra_out), .rb_out(rb_out), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] a;
        logic [7:0] d;
        int e;
    } ent_t;

    ent_t q[$];
    logic [7:0] rf_mem [64];
    int checks = 0, errors = 0, edges = 0;
    bit armed = 0, fix_rd = 0;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at edge %0d", n, act, exp, edges);
        end
    endfunction

    always @(posedge clk) edges <= edges + 1;

    always @(posedge clk) begin
        #2;
        if (!fix_rd) begin
            aa = 6'($urandom_range(0, 15));
            ab = 6'($urandom_range(0, 15));
            rf_ra = 8'($urandom);
            rf_rb = 8'($urandom);
        end
    end

    // Model: an accepted entry pushed at edge p sits in the issue register from edge p+1
    // once it reaches the head, and leaves on the first granted edge after that.
    always @(negedge clk) begin
        bit exp_wr;
        logic [7:0] ea, eb;
        if (armed) begin
            exp_wr = q.size() > 0 && q[0].e < edges;
            chk("count", 32'(count), 32'(q.size()));
            chk("rf_wr", 32'(rf_wr), 32'(exp_wr));
            chk("in_ready", 32'(in_ready), 32'((q.size() - int'(exp_wr)) < 4));
            if (exp_wr) begin
                chk("rf_ad", 32'(rf_ad), 32'(q[0].a));
                chk("rf_rd", 32'(rf_rd), 32'(q[0].d));
            end
            ea = rf_ra;
            eb = rf_rb;
`ifdef WB_BYPASS_EN
            foreach (q[i]) begin
                if (q[i].a == aa) ea = q[i].d;
                if (q[i].a == ab) eb = q[i].d;
            end
`endif
            chk("ra_out", 32'(ra_out), 32'(ea));
            chk("rb_out", 32'(rb_out), 32'(eb));
            if (!rst) begin
                if (rf_wr && rf_gnt) begin
                    rf_mem[rf_ad] = rf_rd;
                    if (q.size() > 0) void'(q.pop_front());
                end
                if (in_valid && in_ready) q.push_back('{in_addr, in_data, edges + 1});
            end
        end
        if (rst) begin
            q.delete();
            armed = 1;
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(logic [5:0] a, logic [7:0] d);
        bit ok;
        int tries = 0;
        in_valid = 1;
        in_addr = a;
        in_data = d;
        do begin
            @(negedge clk);
            ok = in_ready;
            step();
            tries++;
        end while (!ok && tries < 200);
        if (!ok) begin
            errors++;
            $display("FAIL push_timeout got in_ready 0 expected 1");
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        rf_gnt = 1;
        while (count != 0 && t < 200) begin
            step();
            t++;
        end
        checks++;
        if (count != 0) begin
            errors++;
            $display("FAIL drain_timeout got count %0d expected 0", count);
        end
        step(2);
    endtask

    initial begin
        foreach (rf_mem[i]) rf_mem[i] = 0;
        step(2);
        rst = 0;
        @(negedge clk);
        chk("reset_rf_ad", 32'(rf_ad), 0);
        chk("reset_rf_rd", 32'(rf_rd), 0);
        step();

        // reset with three entries pending
        push(6'd3, 8'd1);
        push(6'd4, 8'd2);
        push(6'd5, 8'd3);
        rst = 1;
        step(2);
        rst = 0;
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_rf_ad", 32'(rf_ad), 0);
        step(4);

        // single write
        rf_gnt = 1;
        push(6'd1, 8'd12);
        step(4);
        chk("single_commit", 32'(rf_mem[1]), 12);

        // backpressure then release
        rf_gnt = 0;
        for (int i = 0; i < 5; i++) push(6'(20 + i), 8'(8'h50 + i));
        step(3);
        @(negedge clk);
        chk("bp_count", 32'(count), 5);
        chk("bp_in_ready", 32'(in_ready), 0);
        step();
        drain();
        for (int i = 0; i < 5; i++) chk("bp_commit", 32'(rf_mem[20 + i]), 32'(8'h50 + i));

        // ordering with wrap and random grant
        fork
            for (int i = 1; i <= 10; i++) push(6'd10, 8'(i));
            repeat (40) begin
                rf_gnt = 1'($urandom);
                step();
            end
        join
        drain();
        chk("order_addr10", 32'(rf_mem[10]), 10);

        // forwarding
        rf_gnt = 0;
        fix_rd = 1;
        aa = 6'd10;
        ab = 6'd1;
        rf_ra = 8'h00;
        rf_rb = 8'h5a;
        push(6'd10, 8'h33);
        push(6'd10, 8'h44);
        @(negedge clk);
`ifdef WB_BYPASS_EN
        chk("bypass_ra", 32'(ra_out), 32'h44);
`else
        chk("bypass_ra", 32'(ra_out), 32'h00);
`endif
        chk("bypass_rb", 32'(rb_out), 32'h5a);
        step();
        drain();
        fix_rd = 0;

        // steady push/pop at occupancy 2
        rf_gnt = 0;
        push(6'd7, 8'd70);
        push(6'd7, 8'd71);
        in_valid = 1;
        rf_gnt = 1;
        for (int i = 0; i < 8; i++) begin
            in_addr = 6'd8;
            in_data = 8'(80 + i);
            step();
            @(negedge clk);
            chk("steady_count", 32'(count), 2);
        end
        in_valid = 0;
        drain();
        chk("steady_last", 32'(rf_mem[8]), 87);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom);
            in_addr = 6'($urandom_range(0, 15));
            in_data = 8'($urandom);
            rf_gnt = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
